// File: rtl/sign_ext_pkg.sv
// Shared types and defaults for the immediate/halfword extender.
// Extension modes and default datapath widths.
package sign_ext_pkg;

  typedef enum logic [1:0] {
    SEXT_HALF = 2'b00,
    ZEXT_HALF = 2'b01,
    SEXT_BYTE = 2'b10,
    ZEXT_BYTE = 2'b11
  } ext_mode_t;

  localparam int DEF_IN_WIDTH  = 16;
  localparam int DEF_OUT_WIDTH = 32;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/sign_ext_core.sv
// Combinational sign/zero extension of a halfword or its low byte.
// Unknown or unlisted modes fall back to halfword sign extension.
module sign_ext_core
  import sign_ext_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic [IN_WIDTH-1:0]  A,
  input  logic [1:0]           ext_mode,
  output logic [OUT_WIDTH-1:0] Y
);

  logic [BYTE_W-1:0] w_byte;
  logic              w_half_msb;
  logic              w_byte_msb;

  assign w_byte     = A[BYTE_W-1:0];
  assign w_half_msb = A[IN_WIDTH-1];
  assign w_byte_msb = A[BYTE_W-1];

  always_comb begin
    Y = {{(OUT_WIDTH-IN_WIDTH){w_half_msb}}, A};
    case (ext_mode)
      ZEXT_HALF:
        Y = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, A};
      SEXT_BYTE:
        Y = {{(OUT_WIDTH-BYTE_W){w_byte_msb}},
             w_byte};
      ZEXT_BYTE:
        Y = {{(OUT_WIDTH-BYTE_W){1'b0}}, w_byte};
      default:
        Y = {{(OUT_WIDTH-IN_WIDTH){w_half_msb}}, A};
    endcase
  end

endmodule

// File: rtl/sign_extension.sv
// Immediate widener: combinational result plus a 1-cycle registered copy.
// B holds its last value when no new input is valid.
module sign_extension
  import sign_ext_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [1:0]           ext_mode,
  input  logic [IN_WIDTH-1:0]  A,
  output logic [OUT_WIDTH-1:0] B_comb,
  output logic [OUT_WIDTH-1:0] B,
  output logic                 out_valid
);

  generate
    if (IN_WIDTH < BYTE_W) begin : g_bad_in
      $error("IN_WIDTH must be >= 8");
    end
    if (OUT_WIDTH <= IN_WIDTH) begin : g_bad_out
      $error("OUT_WIDTH must exceed IN_WIDTH");
    end
  endgenerate

  logic [OUT_WIDTH-1:0] w_ext;
  logic [OUT_WIDTH-1:0] r_b;
  logic                 r_valid;

  sign_ext_core #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_core (
    .A        (A),
    .ext_mode (ext_mode),
    .Y        (w_ext)
  );

  // Reset wins over a simultaneous capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_b     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_b <= w_ext;
      end
    end
  end

  assign B_comb    = w_ext;
  assign B         = r_b;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_sign_extension.sv
// Self-checking bench for sign_extension against an arithmetic model.
module tb_sign_extension;
  import sign_ext_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  ext_mode;
  logic [15:0] A;
  logic [31:0] B_comb;
  logic [31:0] B;
  logic        out_valid;

  int tests = 0;
  int fails = 0;

  sign_extension dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .ext_mode  (ext_mode),
    .A         (A),
    .B_comb    (B_comb),
    .B         (B),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Reference: interpret the selected field as a signed or
  // unsigned integer, then take its 32-bit two's complement.
  function automatic logic [31:0] ref_ext(
    input logic [1:0] m, input logic [15:0] a);
    longint v;
    case (m)
      2'd1: v = longint'(a);
      2'd2: begin
        v = longint'(a) % 256;
        if (v >= 128) v = v - 256;
      end
      2'd3: v = longint'(a) % 256;
      default: begin
        v = longint'(a);
        if (v >= 32768) v = v - 65536;
      end
    endcase
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1;
    ext_mode = 2'b00; A = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (B !== 32'h0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset B=%h ov=%b want 0/0",
                 B, out_valid);
      end
    end
    reset = 1'b0;
    tick();
    tests++;
    if (B !== 32'hFFFFFFFF || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL post_reset B=%h ov=%b want ffffffff/1",
               B, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  m [10];
    logic [15:0] a [10];
    logic [31:0] e [10];
    m = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
          2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    a = '{16'h0000, 16'd45, 16'd29, 16'hFFE3, 16'hFFBB,
          16'h8000, 16'hFFBB, 16'h12BB, 16'h12BB, 16'h8000};
    e = '{32'h0, 32'h2D, 32'h1D, 32'hFFFFFFE3,
          32'hFFFFFFBB, 32'hFFFF8000, 32'h0000FFBB,
          32'hFFFFFFBB, 32'h000000BB, 32'h00008000};
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; ext_mode = m[i]; A = a[i];
      #1;
      tests++;
      if (B_comb !== e[i]) begin
        fails++;
        $display("FAIL dir_comb[%0d] got %h want %h",
                 i, B_comb, e[i]);
      end
      tick();
      tests++;
      if (B !== e[i] || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL dir_reg[%0d] got %h/%b want %h/1",
                 i, B, out_valid, e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    logic [31:0] last;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      ext_mode = 2'($urandom_range(0, 3));
      A = 16'($urandom);
      exp_q.push_back(ref_ext(ext_mode, A));
      tick();
      last = exp_q.pop_front();
      tests++;
      if (B !== last || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL b2b[%0d] got %h/%b want %h/1",
                 i, B, out_valid, last);
      end
    end
    in_valid = 1'b0; A = 16'h5A5A;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (B !== last || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL b2b_hold[%0d] got %h/%b want %h/0",
                 i, B, out_valid, last);
      end
    end
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1; ext_mode = 2'b00; A = 16'h1234;
    tick();
    reset = 1'b1; ext_mode = 2'b10; A = 16'h0080;
    #1;
    tests++;
    if (B_comb !== 32'hFFFFFF80) begin
      fails++;
      $display("FAIL mid_comb got %h want ffffff80", B_comb);
    end
    tick();
    tests++;
    if (B !== 32'h0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got %h/%b want 0/0",
               B, out_valid);
    end
    tests++;
    if (B_comb !== 32'hFFFFFF80) begin
      fails++;
      $display("FAIL mid_comb_rst got %h want ffffff80",
               B_comb);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_b;
    logic        exp_v;
    logic [31:0] ec;
    in_valid = 1'b1; ext_mode = 2'b01; A = 16'h0001;
    tick();
    exp_b = 32'h1;
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      ext_mode = 2'($urandom_range(0, 3));
      A = 16'($urandom);
      ec = ref_ext(ext_mode, A);
      #1;
      tests++;
      if (B_comb !== ec) begin
        fails++;
        $display("FAIL rnd_comb[%0d] m=%0d a=%h got %h want %h",
                 i, ext_mode, A, B_comb, ec);
      end
      if (in_valid) exp_b = ec;
      exp_v = in_valid;
      tick();
      tests++;
      if (B !== exp_b || out_valid !== exp_v) begin
        fails++;
        $display("FAIL rnd_reg[%0d] got %h/%b want %h/%b",
                 i, B, out_valid, exp_b, exp_v);
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0;
    ext_mode = 2'b00; A = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
